// File: rtl/tube_bus_arbiter_if.sv
// Bus bundle between the two tube-register masters, the arbiter and the tube register slave.
// The arbiter connects through the slave modport; the master modport is the environment side.
interface tube_bus_arbiter_if;
    logic        m0_req;
    logic        m0_lock;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_lock;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;

    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic        slv_we;
    logic [31:0] slv_rdata;

    modport master (
        output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  slv_addr, slv_wdata, slv_we,
        output slv_rdata
    );

    modport slave (
        input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output slv_addr, slv_wdata, slv_we,
        input  slv_rdata
    );
endinterface

// File: rtl/tube_bus_arbiter.sv
// Two-master round-robin arbiter with burst lock for the digital tube register port.
// Optional: define ARB_TIMEOUT_EN to drop a lock whose owner idles for LOCK_TIMEOUT cycles.
module tube_bus_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_7f38,
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    tube_bus_arbiter_if.slave bus,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        rr_ptr, lock_vld, lock_id, gnt_id, err_flag;
    logic [3:0]  burst_cnt;
    logic        owner_req, owner_lock, gnt_lock;
    logic        timeout_hit, lock_release, lock_hold;
    logic        win, win_id, win_ok, win_we;
    logic [31:0] win_addr, win_wdata;

    if (MAX_BURST < 1 || MAX_BURST > 15 || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 31) begin : g_cfg_check
        $error("tube_bus_arbiter: MAX_BURST must be 1..15 and LOCK_TIMEOUT 1..31");
    end

    assign owner_req  = lock_id ? bus.m1_req  : bus.m0_req;
    assign owner_lock = lock_id ? bus.m1_lock : bus.m0_lock;
    assign gnt_lock   = gnt_id  ? bus.m1_lock : bus.m0_lock;

`ifdef ARB_TIMEOUT_EN
    logic [4:0] idle_cnt;
    logic       idle_run;

    assign idle_run    = (state == IDLE) && lock_vld && owner_lock && !owner_req;
    assign timeout_hit = idle_run && (idle_cnt == 5'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= 5'd0;
        end else if (idle_run && !timeout_hit) begin
            idle_cnt <= idle_cnt + 5'd1;
        end else begin
            idle_cnt <= 5'd0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Winner selection: a live lock owner blocks the other master even while it is not requesting.
    always_comb begin
        lock_release = (state == IDLE) && lock_vld && (!owner_lock || timeout_hit);
        lock_hold    = lock_vld && !lock_release;
        win          = 1'b0;
        win_id       = rr_ptr;
        if (lock_hold) begin
            win    = owner_req;
            win_id = lock_id;
        end else if (bus.m0_req && bus.m1_req) begin
            win    = 1'b1;
            win_id = lock_release ? ~lock_id : rr_ptr;
        end else if (bus.m0_req) begin
            win    = 1'b1;
            win_id = 1'b0;
        end else if (bus.m1_req) begin
            win    = 1'b1;
            win_id = 1'b1;
        end
        win_addr  = win_id ? bus.m1_addr  : bus.m0_addr;
        win_wdata = win_id ? bus.m1_wdata : bus.m0_wdata;
        win_we    = win_id ? bus.m1_we    : bus.m0_we;
        win_ok    = (win_addr[1:0] == 2'b00) &&
                    ((win_addr == BASE_ADDR) || (win_addr == BASE_ADDR + 32'd4));

        state_nxt = state;
        case (state)
            IDLE:    if (win) state_nxt = win_ok ? ISSUE : RESP;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            lock_vld      <= 1'b0;
            lock_id       <= 1'b0;
            burst_cnt     <= 4'd0;
            gnt_id        <= 1'b0;
            err_flag      <= 1'b0;
            busy          <= 1'b0;
            bus.m0_ack    <= 1'b0;
            bus.m0_err    <= 1'b0;
            bus.m1_ack    <= 1'b0;
            bus.m1_err    <= 1'b0;
            bus.m0_rdata  <= 32'd0;
            bus.m1_rdata  <= 32'd0;
            bus.slv_addr  <= 32'd0;
            bus.slv_wdata <= 32'd0;
            bus.slv_we    <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != IDLE);
            bus.m0_ack <= 1'b0;
            bus.m0_err <= 1'b0;
            bus.m1_ack <= 1'b0;
            bus.m1_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (lock_release) begin
                        lock_vld  <= 1'b0;
                        burst_cnt <= 4'd0;
                        rr_ptr    <= ~lock_id;
                    end
                    if (win) begin
                        gnt_id   <= win_id;
                        err_flag <= !win_ok;
                        if (win_ok) begin
                            bus.slv_addr  <= win_addr;
                            bus.slv_wdata <= win_wdata;
                            bus.slv_we    <= win_we;
                        end
                    end
                end
                ISSUE: begin
                    // Writes return the value the slave presented before the commit edge.
                    if (gnt_id) bus.m1_rdata <= bus.slv_rdata;
                    else        bus.m0_rdata <= bus.slv_rdata;
                    bus.slv_addr  <= 32'd0;
                    bus.slv_wdata <= 32'd0;
                    bus.slv_we    <= 1'b0;
                end
                RESP: begin
                    if (gnt_id) begin
                        bus.m1_ack <= !err_flag;
                        bus.m1_err <= err_flag;
                    end else begin
                        bus.m0_ack <= !err_flag;
                        bus.m0_err <= err_flag;
                    end
                    if (gnt_lock && (({1'b0, burst_cnt} + 5'd1) < 5'(MAX_BURST))) begin
                        lock_vld  <= 1'b1;
                        lock_id   <= gnt_id;
                        burst_cnt <= burst_cnt + 4'd1;
                    end else begin
                        lock_vld  <= 1'b0;
                        burst_cnt <= 4'd0;
                        rr_ptr    <= ~gnt_id;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tube_bus_arbiter.sv
// Directed bench for tube_bus_arbiter: a scoreboard of expected completions checked on every ack/err.
module tb_tube_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;

    tube_bus_arbiter_if bus();

    tube_bus_arbiter #(
        .BASE_ADDR(32'h0000_7f38),
        .MAX_BURST(4),
        .LOCK_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Tube register slave: combinational read, write committed on the clock edge.
    logic [31:0] sreg0 = 32'd0;
    logic [31:0] sreg1 = 32'd0;
    assign bus.slv_rdata = (bus.slv_addr == 32'h7f38) ? sreg0 :
                           (bus.slv_addr == 32'h7f3c) ? sreg1 : 32'hdead_beef;
    always @(posedge clk) begin
        if (bus.slv_we && bus.slv_addr == 32'h7f38) sreg0 <= bus.slv_wdata;
        if (bus.slv_we && bus.slv_addr == 32'h7f3c) sreg1 <= bus.slv_wdata;
    end

    typedef struct {
        int          mid;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl[2];
    logic [31:0] exp_rd[2];
    int          last_lat;
    int          we_cnt;
    logic [31:0] we_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int m, input bit req, input bit lock, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_lock = lock; bus.m0_we = we;
            bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = req; bus.m1_lock = lock; bus.m1_we = we;
            bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
    endtask

    task automatic expect_xfer(input int m, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata);
        exp_t e;
        int   idx;
        e.mid = m;
        e.err = !(addr == 32'h7f38 || addr == 32'h7f3c);
        if (e.err) begin
            e.rdata = exp_rd[m];
        end else begin
            idx = (addr == 32'h7f3c) ? 1 : 0;
            e.rdata = mdl[idx];
            if (we) mdl[idx] = wdata;
        end
        exp_rd[m] = e.rdata;
        sb.push_back(e);
    endtask

    task automatic wait_cmpl(input string tag, input int budget);
        int   cyc;
        bit   got;
        int   oid;
        exp_t e;
        cyc = 0; got = 1'b0; we_cnt = 0; we_addr = 32'd0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.slv_we) begin
                we_cnt++;
                we_addr = bus.slv_addr;
            end
            got = bus.m0_ack | bus.m0_err | bus.m1_ack | bus.m1_err;
        end
        last_lat = cyc;
        check({tag, " done"}, 32'(got), 32'd1);
        if (!got) return;
        check({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        oid = (bus.m1_ack | bus.m1_err) ? 1 : 0;
        check({tag, " onehot"}, 32'($countones({bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err})), 32'd1);
        check({tag, " master"}, 32'(oid), 32'(e.mid));
        check({tag, " err"}, 32'(bus.m0_err | bus.m1_err), 32'(e.err));
        check({tag, " rdata"}, (oid == 1) ? bus.m1_rdata : bus.m0_rdata, e.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        set_m(0, 0, 0, 0, 32'd0, 32'd0);
        set_m(1, 0, 0, 0, 32'd0, 32'd0);
        mdl[0] = 32'd0; mdl[1] = 32'd0;
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst m0_ack", 32'(bus.m0_ack), 32'd0);
        check("rst m1_err", 32'(bus.m1_err), 32'd0);
        check("rst m0_rdata", bus.m0_rdata, 32'd0);
        check("rst slv_we", 32'(bus.slv_we), 32'd0);
        check("rst slv_addr", bus.slv_addr, 32'd0);
        reset = 1'b1;

        // Single write, readback, and a write from the other master.
        expect_xfer(0, 1'b1, 32'h7f38, 32'h1234_5678);
        set_m(0, 1, 0, 1, 32'h7f38, 32'h1234_5678);
        wait_cmpl("wr0", 10);
        check("wr0 latency", 32'(last_lat), 32'd3);
        check("wr0 we_cycles", 32'(we_cnt), 32'd1);
        check("wr0 slv_addr", we_addr, 32'h7f38);
        set_m(0, 0, 0, 0, 32'd0, 32'd0);

        expect_xfer(0, 1'b0, 32'h7f38, 32'd0);
        set_m(0, 1, 0, 0, 32'h7f38, 32'd0);
        wait_cmpl("rd0", 10);
        check("rd0 latency", 32'(last_lat), 32'd3);
        check("rd0 we_cycles", 32'(we_cnt), 32'd0);
        set_m(0, 0, 0, 0, 32'd0, 32'd0);

        expect_xfer(1, 1'b1, 32'h7f3c, 32'ha5a5_0f0f);
        set_m(1, 1, 0, 1, 32'h7f3c, 32'ha5a5_0f0f);
        wait_cmpl("wr1", 10);
        check("wr1 latency", 32'(last_lat), 32'd3);
        check("wr1 slv_addr", we_addr, 32'h7f3c);
        set_m(1, 0, 0, 0, 32'd0, 32'd0);

        // Simultaneous requests alternate m0, m1, m0, m1.
        for (int i = 0; i < 2; i++) begin
            expect_xfer(0, 1'b0, 32'h7f38, 32'd0);
            expect_xfer(1, 1'b0, 32'h7f3c, 32'd0);
        end
        set_m(0, 1, 0, 0, 32'h7f38, 32'd0);
        set_m(1, 1, 0, 0, 32'h7f3c, 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_cmpl("rr", 10);
            check("rr latency", 32'(last_lat), 32'd3);
        end
        set_m(0, 0, 0, 0, 32'd0, 32'd0);
        set_m(1, 0, 0, 0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("rr idle busy", 32'(busy), 32'd0);

        // Decode errors: out of window and misaligned.
        expect_xfer(1, 1'b0, 32'h7f40, 32'd0);
        set_m(1, 1, 0, 0, 32'h7f40, 32'd0);
        wait_cmpl("err_win", 10);
        check("err_win latency", 32'(last_lat), 32'd2);
        check("err_win we_cycles", 32'(we_cnt), 32'd0);
        set_m(1, 0, 0, 0, 32'd0, 32'd0);
        expect_xfer(1, 1'b0, 32'h7f3a, 32'd0);
        set_m(1, 1, 0, 0, 32'h7f3a, 32'd0);
        wait_cmpl("err_align", 10);
        check("err_align latency", 32'(last_lat), 32'd2);
        check("err_align we_cycles", 32'(we_cnt), 32'd0);
        set_m(1, 0, 0, 0, 32'd0, 32'd0);

        // Burst lock: m0 keeps four grants, then m1, then m0 again.
        for (int i = 0; i < 4; i++) expect_xfer(0, 1'b0, 32'h7f38, 32'd0);
        expect_xfer(1, 1'b0, 32'h7f3c, 32'd0);
        expect_xfer(0, 1'b0, 32'h7f38, 32'd0);
        set_m(0, 1, 1, 0, 32'h7f38, 32'd0);
        set_m(1, 1, 0, 0, 32'h7f3c, 32'd0);
        for (int i = 0; i < 6; i++) wait_cmpl("lock", 10);
        set_m(0, 0, 0, 0, 32'd0, 32'd0);
        set_m(1, 0, 0, 0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("lock idle busy", 32'(busy), 32'd0);

        // Owner idles with lock held while m1 requests.
        expect_xfer(0, 1'b0, 32'h7f38, 32'd0);
        set_m(0, 1, 1, 0, 32'h7f38, 32'd0);
        wait_cmpl("hold_own", 10);
        bus.m0_req = 1'b0;
        set_m(1, 1, 0, 0, 32'h7f3c, 32'd0);
`ifdef ARB_TIMEOUT_EN
        expect_xfer(1, 1'b0, 32'h7f3c, 32'd0);
        wait_cmpl("hold_timeout", 30);
        check("hold_timeout window", 32'(last_lat >= 16 && last_lat <= 20), 32'd1);
`else
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.m1_ack || bus.m1_err || busy) seen++;
        end
        check("hold_blocked", 32'(seen), 32'd0);
        expect_xfer(1, 1'b0, 32'h7f3c, 32'd0);
        bus.m0_lock = 1'b0;
        wait_cmpl("hold_release", 10);
        check("hold_release latency", 32'(last_lat), 32'd3);
`endif
        set_m(0, 0, 0, 0, 32'd0, 32'd0);
        set_m(1, 0, 0, 0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        // Reset during ISSUE of an m1 write abandons it.
        set_m(1, 1, 0, 1, 32'h7f3c, 32'hcafe_f00d);
        @(negedge clk);
        check("mid_rst pre slv_we", 32'(bus.slv_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst slv_we", 32'(bus.slv_we), 32'd0);
        check("mid_rst slv_addr", bus.slv_addr, 32'd0);
        check("mid_rst busy", 32'(busy), 32'd0);
        check("mid_rst m1_rdata", bus.m1_rdata, 32'd0);
        check("mid_rst m0_rdata", bus.m0_rdata, 32'd0);
        bus.m1_req = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst no_commit", sreg1, mdl[1]);
        reset = 1'b1;
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.m0_ack || bus.m1_ack || bus.m0_err || bus.m1_err) seen++;
        end
        check("mid_rst no_ack", 32'(seen), 32'd0);

        expect_xfer(0, 1'b0, 32'h7f38, 32'd0);
        expect_xfer(1, 1'b0, 32'h7f3c, 32'd0);
        set_m(0, 1, 0, 0, 32'h7f38, 32'd0);
        set_m(1, 1, 0, 0, 32'h7f3c, 32'd0);
        for (int i = 0; i < 2; i++) wait_cmpl("post_rst", 10);
        set_m(0, 0, 0, 0, 32'd0, 32'd0);
        set_m(1, 0, 0, 0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("sb drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
